// File: rtl/irq_ctl_if.sv
// CPU-side bus of the interrupt controller: a 4-word register window with
// byte write enables and a combinational read port.
interface irq_ctl_if;
   logic        select;
   logic [3:0]  we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (
      output select,
      output we,
      output addr,
      output wdata,
      input  rdata
   );

   modport slave (
      input  select,
      input  we,
      input  addr,
      input  wdata,
      output rdata
   );
endinterface

// File: rtl/irq_ctl.sv
// Memory-mapped interrupt controller: per-source synchroniser, level/edge
// capture, enable mask and fixed priority encoder driving a registered irq.
module irq_ctl #(
   parameter int          NUM_SRC     = 8,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] RESET_MODE  = 32'h0000_0000
) (
   input  logic               input_clk,
   input  logic               reset,
   irq_ctl_if.slave           bus,
   input  logic [NUM_SRC-1:0] src,
   output logic               irq,
   output logic [4:0]         vector
);

   localparam logic [1:0] ADDR_PENDING = 2'd0;
   localparam logic [1:0] ADDR_ENABLE  = 2'd1;
   localparam logic [1:0] ADDR_MODE    = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   // Byte-lane merge: bits in enabled lanes take the new value, others keep old.
   function automatic logic [NUM_SRC-1:0] lane_merge(
      input logic [NUM_SRC-1:0] old_v,
      input logic [31:0]        new_v,
      input logic [3:0]         lanes
   );
      logic [NUM_SRC-1:0] res;
      for (int i = 0; i < NUM_SRC; i++) begin
         res[i] = lanes[i >> 3] ? new_v[i] : old_v[i];
      end
      return res;
   endfunction

   logic [NUM_SRC-1:0] sync_r [SYNC_STAGES];
   logic [NUM_SRC-1:0] sync_s;
   logic [NUM_SRC-1:0] prev_r;
   logic [NUM_SRC-1:0] enable_r;
   logic [NUM_SRC-1:0] mode_r;
   logic [NUM_SRC-1:0] edge_r;
   logic               irq_r;
   logic [4:0]         vector_r;

   logic               wr_s;
   logic [NUM_SRC-1:0] enable_nxt_s;
   logic [NUM_SRC-1:0] mode_nxt_s;
   logic [NUM_SRC-1:0] clr_s;
   logic [NUM_SRC-1:0] mode_chg_s;
   logic [NUM_SRC-1:0] rise_s;
   logic [NUM_SRC-1:0] edge_nxt_s;
   logic [NUM_SRC-1:0] pending_s;
   logic [NUM_SRC-1:0] active_s;
   logic [4:0]         vec_s;
   logic [31:0]        rdata_s;

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Synchroniser chain plus the one-cycle delayed copy used for edge detect.
   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= '0;
         end
         prev_r <= '0;
      end else begin
         sync_r[0] <= src;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
         prev_r <= sync_s;
      end
   end

   // Register write decode and capture logic.
   always_comb begin
      wr_s         = bus.select & (|bus.we);
      enable_nxt_s = enable_r;
      mode_nxt_s   = mode_r;
      clr_s        = '0;
      if (wr_s) begin
         case (bus.addr)
            ADDR_PENDING: clr_s        = lane_merge('0, bus.wdata, bus.we);
            ADDR_ENABLE:  enable_nxt_s = lane_merge(enable_r, bus.wdata, bus.we);
            ADDR_MODE:    mode_nxt_s   = lane_merge(mode_r, bus.wdata, bus.we);
            ADDR_STATUS:  clr_s        = '0;
            default:      clr_s        = '0;
         endcase
      end else begin
         clr_s = '0;
      end
      mode_chg_s = mode_r ^ mode_nxt_s;
      rise_s     = sync_s & ~prev_r;
      // Set beats W1C; level-mode bits and bits whose mode flips hold the latch at 0.
      edge_nxt_s = (rise_s | (edge_r & ~clr_s)) & mode_r & ~mode_chg_s;
      pending_s  = (mode_r & edge_r) | (~mode_r & sync_s);
      active_s   = pending_s & enable_r;
      vec_s      = 5'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         vec_s = active_s[i] ? 5'(i) : vec_s;
      end
   end

   // Control registers and edge latches.
   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         enable_r <= '0;
         mode_r   <= RESET_MODE[NUM_SRC-1:0];
         edge_r   <= '0;
      end else begin
         enable_r <= enable_nxt_s;
         mode_r   <= mode_nxt_s;
         edge_r   <= edge_nxt_s;
      end
   end

   // Registered request and vector to the CPU.
   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         irq_r    <= 1'b0;
         vector_r <= 5'd0;
      end else begin
         irq_r    <= |active_s;
         vector_r <= vec_s;
      end
   end

   // Read mux; bits at and above NUM_SRC read as zero.
   always_comb begin
      rdata_s = 32'h0000_0000;
      case (bus.addr)
         ADDR_PENDING: rdata_s = 32'(pending_s);
         ADDR_ENABLE:  rdata_s = 32'(enable_r);
         ADDR_MODE:    rdata_s = 32'(mode_r);
         ADDR_STATUS:  rdata_s = {irq_r, 26'd0, vector_r};
         default:      rdata_s = 32'h0000_0000;
      endcase
   end

   assign bus.rdata = rdata_s;
   assign irq       = irq_r;
   assign vector    = vector_r;

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl with hand-computed expectations.
module tb_irq_ctl;

   localparam logic [1:0] A_PEND = 2'd0;
   localparam logic [1:0] A_EN   = 2'd1;
   localparam logic [1:0] A_MODE = 2'd2;
   localparam logic [1:0] A_STAT = 2'd3;

   logic       clk;
   logic       reset;
   logic [7:0] src;
   logic       irq;
   logic [4:0] vector;
   int         n_checks;
   int         n_errors;

   irq_ctl_if bus_if ();

   irq_ctl #(
      .NUM_SRC     (8),
      .SYNC_STAGES (2),
      .RESET_MODE  (32'h0000_0000)
   ) dut (
      .input_clk (clk),
      .reset     (reset),
      .bus       (bus_if),
      .src       (src),
      .irq       (irq),
      .vector    (vector)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      bus_if.select = 1'b1;
      bus_if.we     = be;
      bus_if.addr   = a;
      bus_if.wdata  = d;
      @(negedge clk);
      bus_if.select = 1'b0;
      bus_if.we     = 4'h0;
   endtask

   task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
      bus_if.addr = a;
      #1;
      check(tag, bus_if.rdata, exp);
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      reset         = 1'b1;
      src           = 8'h00;
      bus_if.select = 1'b0;
      bus_if.we     = 4'h0;
      bus_if.addr   = 2'd0;
      bus_if.wdata  = 32'h0000_0000;
      tick(2);
      reset = 1'b0;

      // reset state
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_vec", {27'd0, vector}, 32'd0);
      check_reg("rst_en", A_EN, 32'h0);
      check_reg("rst_mode", A_MODE, 32'h0);
      check_reg("rst_pend", A_PEND, 32'h0);

      // mid-run reset with everything enabled and all sources high
      wr(A_EN, 32'h0000_00FF, 4'hF);
      src = 8'hFF;
      tick(4);
      check("pre_rst_irq", {31'd0, irq}, 32'd1);
      reset = 1'b1;
      tick(1);
      check("mid_rst_irq", {31'd0, irq}, 32'd0);
      check("mid_rst_vec", {27'd0, vector}, 32'd0);
      check_reg("mid_rst_en", A_EN, 32'h0);
      check_reg("mid_rst_mode", A_MODE, 32'h0);
      check_reg("mid_rst_pend", A_PEND, 32'h0);
      reset = 1'b0;
      tick(1);
      check_reg("post_rst_pend1", A_PEND, 32'h0);
      tick(1);
      check_reg("post_rst_pend2", A_PEND, 32'hFF);
      check("post_rst_irq", {31'd0, irq}, 32'd0);

      // level mode on source 4
      src = 8'h00;
      tick(3);
      wr(A_EN, 32'h0000_0010, 4'hF);
      src = 8'h10;
      for (int j = 1; j <= 8; j++) begin
         tick(1);
         check_reg("lvl_pend", A_PEND, (j >= 2 && j <= 6) ? 32'h10 : 32'h0);
         check("lvl_irq", {31'd0, irq}, (j >= 3 && j <= 7) ? 32'd1 : 32'd0);
         if (j == 3) check_reg("lvl_status", A_STAT, 32'h8000_0004);
         if (j == 5) src = 8'h00;
      end

      // edge mode with write-1-to-clear on source 0
      wr(A_MODE, 32'h0000_0001, 4'hF);
      wr(A_EN, 32'h0000_0001, 4'hF);
      src = 8'h01;
      tick(2);
      check_reg("edge_pend_early", A_PEND, 32'h0);
      tick(1);
      check_reg("edge_pend", A_PEND, 32'h1);
      check("edge_irq_early", {31'd0, irq}, 32'd0);
      tick(1);
      check("edge_irq", {31'd0, irq}, 32'd1);
      check_reg("edge_status", A_STAT, 32'h8000_0000);
      wr(A_PEND, 32'h0000_0001, 4'hF);
      check_reg("w1c_pend", A_PEND, 32'h0);
      check("w1c_irq_lag", {31'd0, irq}, 32'd1);
      tick(1);
      check("w1c_irq", {31'd0, irq}, 32'd0);
      tick(3);
      check("held_irq", {31'd0, irq}, 32'd0);
      check_reg("held_pend", A_PEND, 32'h0);
      src = 8'h00;
      tick(3);
      src = 8'h01;
      tick(4);
      check("reedge_irq", {31'd0, irq}, 32'd1);
      src = 8'h00;
      tick(3);
      wr(A_PEND, 32'h0000_0001, 4'hF);
      wr(A_EN, 32'h0000_0000, 4'hF);
      wr(A_MODE, 32'h0000_0000, 4'hF);
      tick(2);

      // W1C in the same cycle the edge is detected: set wins
      wr(A_MODE, 32'h0000_0002, 4'hF);
      wr(A_EN, 32'h0000_0002, 4'hF);
      src = 8'h02;
      tick(2);
      wr(A_PEND, 32'h0000_0002, 4'hF);
      check_reg("setclr_pend", A_PEND, 32'h2);
      tick(1);
      check("setclr_irq", {31'd0, irq}, 32'd1);
      src = 8'h00;
      tick(3);
      wr(A_PEND, 32'h0000_0002, 4'hF);
      wr(A_EN, 32'h0000_0000, 4'hF);
      tick(1);
      check_reg("setclr_clean", A_PEND, 32'h0);

      // masked capture and priority
      wr(A_MODE, 32'h0000_00FF, 4'hF);
      src = 8'h48;
      tick(2);
      src = 8'h00;
      tick(4);
      check("mask_irq", {31'd0, irq}, 32'd0);
      check_reg("mask_pend", A_PEND, 32'h48);
      wr(A_EN, 32'h0000_0048, 4'hF);
      tick(1);
      check("prio_irq", {31'd0, irq}, 32'd1);
      check("prio_vec3", {27'd0, vector}, 32'd3);
      wr(A_PEND, 32'h0000_0008, 4'hF);
      check_reg("prio_pend", A_PEND, 32'h40);
      tick(1);
      check("prio_vec6", {27'd0, vector}, 32'd6);
      check("prio_irq6", {31'd0, irq}, 32'd1);

      // flipping bit 6 to level and back drops its latch
      wr(A_MODE, 32'h0000_00BF, 4'hF);
      check_reg("mchg_pend", A_PEND, 32'h0);
      wr(A_MODE, 32'h0000_00FF, 4'hF);
      check_reg("mchg_pend2", A_PEND, 32'h0);
      tick(1);
      check("mchg_irq", {31'd0, irq}, 32'd0);

      // byte enables, upper bits, ignored writes
      wr(A_EN, 32'h0000_0000, 4'hF);
      wr(A_EN, 32'hFFFF_FFFF, 4'b0010);
      check_reg("be_lane1", A_EN, 32'h0);
      wr(A_EN, 32'hFFFF_FFFF, 4'b0001);
      check_reg("be_lane0", A_EN, 32'hFF);
      wr(A_MODE, 32'hFFFF_FFFF, 4'hF);
      check_reg("mode_upper", A_MODE, 32'hFF);
      wr(A_STAT, 32'h0000_0000, 4'hF);
      check_reg("stat_wr_en", A_EN, 32'hFF);
      check_reg("stat_wr_mode", A_MODE, 32'hFF);
      bus_if.select = 1'b0;
      bus_if.we     = 4'hF;
      bus_if.addr   = A_EN;
      bus_if.wdata  = 32'h0000_0000;
      tick(1);
      bus_if.we = 4'h0;
      check_reg("nosel_en", A_EN, 32'hFF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/irq_ctl.md
Name: irq_ctl

Overview:
Memory-mapped interrupt controller that replaces the flat OR of device interrupt lines feeding the FemtoRV32 interrupt_request input. It takes up to NUM_SRC raw interrupt lines (GP timer, UART valid, Econet RX valid, Econet timer A, SD card detect, and others) and synchronises each one. Per source it provides level or rising-edge capture, a pending register, an enable mask and a priority vector. It drives a single registered irq output to the CPU and sits on the CPU bus as a 4-word peripheral.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..32); source 0 has the highest priority.
SYNC_STAGES, 2, synchroniser flops per source (1..3).
RESET_MODE, 0, reset value of the MODE register (bit=1 selects edge mode).

Ports:
input_clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-high reset.
select  input  1  bus decode for this block's 16-byte window.
we  input  4  byte write enables (same meaning as the CPU mem_wmask).
addr  input  2  word address, taken from mem_addr[3:2].
wdata  input  32  write data.
rdata  output  32  read data (combinational from the registers).
src  input  NUM_SRC  raw interrupt lines, active-high, asynchronous to input_clk.
irq  output  1  registered interrupt request to the CPU.
vector  output  5  index of the highest-priority active source (registered).

Behaviour:
- Reset is asynchronous on all flops.
  - ENABLE=0.
  - MODE=RESET_MODE.
  - Edge latches=0.
  - Synchroniser chains=0.
  - Previous-sync register=0.
  - irq=0, vector=0.
- Synchronisation: s = last stage of a SYNC_STAGES-deep chain per source. s_prev = s delayed by one cycle.
- Register map (word addresses):
  - 0 PENDING: read-only view; write-1-to-clear on edge latches.
  - 1 ENABLE: read/write.
  - 2 MODE: read/write.
  - 3 STATUS: read-only; bit31 = irq; bits[4:0] = vector; bits[NUM_SRC+7:8] are not used, so bits 30:5 read 0.
  - All bits at and above NUM_SRC read 0 and ignore writes.
- Writes:
  - A write occurs only when select=1 and a we bit is set.
  - A write updates only the bytes whose we bit is set.
  - The write takes effect on the next input_clk edge.
  - Writes to address 3 are ignored.
  - Reads have no side effects.
- Per-source pending[i]:
  - MODE[i]=0 (level): pending[i] = s[i]. W1C has no effect, and the edge latch is held at 0.
  - MODE[i]=1 (edge): edge_latch[i] is set when s[i]=1 and s_prev[i]=0. It is cleared by a W1C write with bit i=1.
  - If a set and a clear occur in the same cycle, the set wins and the latch stays 1.
  - Any write to MODE clears the edge latches of every bit whose MODE value changes.
- Enable does not gate capture: an edge arriving while ENABLE[i]=0 stays pending and raises irq when ENABLE[i] is later set.
- active = pending & ENABLE.
- Registered outputs, updated each cycle:
  - irq <= |active.
  - vector <= index of the lowest set bit of active, or 0 if none.
- Latency: a src rising edge that is set up before clock edge k gives:
  - s=1 after edge k+SYNC_STAGES-1;
  - pending visible at the register read port after edge k+SYNC_STAGES-1 (level mode) or k+SYNC_STAGES (edge mode);
  - irq=1 one edge after pending is visible.
- Deassertion: irq drops one edge after the last active bit clears. This may follow a W1C write, an ENABLE write, or a level source going low with the same sync latency.
- Glitch rule: a src pulse shorter than one clock period may be lost. Sources are required to hold for at least 1 cycle; all existing sources are synchronous pulses or levels.
- Priority rule: vector always reports the lowest index. Two sources becoming active in the same cycle give vector = the lower index.
- Edge-mode source held high: after W1C, no re-latch occurs until a new 0→1 transition.

Test Plan:
- Reset: assert reset mid-run with ENABLE=0xFF and src=0xFF → irq=0, vector=0, ENABLE reads 0, MODE reads RESET_MODE, PENDING reads 0x00 until the sync delay elapses.
- Level mode: ENABLE=0x10, then pulse src[4] high for 5 cycles → PENDING bit4 high for 5 cycles after 1 cycle of sync delay. irq is high for 5 cycles, delayed one further cycle. STATUS reads 0x80000004.
- Edge mode with W1C: MODE=0x01, ENABLE=0x01, src[0] rises and stays high → irq=1 at +3 edges. Write PENDING=0x01 → irq=0 one edge later and stays 0 while src[0] is still high. Drop and re-raise src[0] → irq returns.
- Simultaneous set and clear: MODE=0x02, issue W1C 0x02 in the same cycle that s[1] rises → PENDING bit1 reads 1 and irq=1.
- Masked capture and priority: MODE=0xFF, ENABLE=0, pulse src[6] and src[3] → irq stays 0 and PENDING=0x48. Write ENABLE=0x48 → irq=1 and vector=3. W1C 0x08 → vector=6 and irq stays 1.
- Byte enables: write 0xFFFFFFFF to ENABLE with we=0b0010 → ENABLE reads 0x00 for NUM_SRC=8. Write with we=0b0001 → ENABLE reads 0xFF.
